// File: rtl/text_glyph_scheduler.sv
// text_glyph_scheduler: per-pixel text/glyph RAM sequencing with text-RAM write arbitration
module text_glyph_scheduler #(
  parameter int          CELL_W    = 50,
  parameter int          CELL_H    = 50,
  parameter int          COLS      = 12,
  parameter int          ROWS      = 9,
  parameter int          CODE_BASE = 33,
  parameter int          GLYPHS    = 94,
  parameter int          TXT_AW    = 8,
  parameter int          GLY_AW    = 18,
  parameter logic [11:0] BG_COLOR  = 12'h000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_pix_en,
  input  logic              i_active,
  input  logic [9:0]        i_x,
  input  logic [8:0]        i_y,
  output logic [TXT_AW-1:0] o_txt_addr,
  output logic              o_txt_wen,
  output logic [7:0]        o_txt_wdata,
  input  logic [7:0]        i_txt_rdata,
  output logic [GLY_AW-1:0] o_gly_addr,
  input  logic [11:0]       i_gly_rdata,
  input  logic              i_wr_req,
  input  logic [TXT_AW-1:0] i_wr_addr,
  input  logic [7:0]        i_wr_data,
  output logic              o_wr_ack,
  output logic [11:0]       o_pix_color
);
  localparam int PXW  = $clog2(CELL_W);
  localparam int PYW  = $clog2(CELL_H);
  localparam int CW   = $clog2(COLS + 1);
  localparam int RW   = $clog2(ROWS + 1);
  localparam int AREA = CELL_W * CELL_H;
  logic [1:0]        r_phase;
  logic [PXW-1:0]    r_px;
  logic [PYW-1:0]    r_py;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic              r_active;
  logic              r_ok;
  logic              r_fetch;
  logic [11:0]       r_pix;
  logic              w_grant;
  logic              w_code_ok;
  logic [TXT_AW-1:0] w_cell;
  logic [31:0]       w_gly_full;
  always_comb begin
    w_grant     = !reset && i_wr_req && (r_phase == 2'd0 || r_phase == 2'd3);
    w_code_ok   = i_txt_rdata >= 8'(CODE_BASE) && i_txt_rdata <= 8'(CODE_BASE + GLYPHS - 1);
    w_cell      = TXT_AW'(32'(r_row) * 32'(COLS) + 32'(r_col));
    w_gly_full  = (32'(i_txt_rdata) - 32'(CODE_BASE)) * 32'(AREA) + 32'(r_py) * 32'(CELL_W) + 32'(r_px);
    o_txt_wen   = w_grant;
    o_wr_ack    = w_grant;
    o_txt_wdata = w_grant ? i_wr_data : 8'h00;
    o_txt_addr  = w_grant ? i_wr_addr : (!reset && r_phase == 2'd1) ? w_cell : '0;
    o_gly_addr  = (!reset && r_phase == 2'd2) ? w_gly_full[GLY_AW-1:0] : '0;
    o_pix_color = r_pix;
  end
  // r_fetch marks the single phase-3 cycle that follows a real phase 2, so a stalled
  // pixel clock (phase parked at 3) never re-samples the glyph RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase  <= 2'd0;
      r_px     <= '0;
      r_py     <= '0;
      r_col    <= '0;
      r_row    <= '0;
      r_active <= 1'b0;
      r_ok     <= 1'b0;
      r_fetch  <= 1'b0;
      r_pix    <= BG_COLOR;
    end else begin
      r_phase <= i_pix_en ? 2'd0 : (r_phase == 2'd3) ? 2'd3 : r_phase + 2'd1;
      r_fetch <= r_phase == 2'd2;
      if (i_pix_en) begin
        r_active <= i_active;
        if (i_active) begin
          if (i_x == '0) begin
            r_px  <= '0;
            r_col <= '0;
            if (i_y == '0) begin
              r_py  <= '0;
              r_row <= '0;
            end else if (r_py == PYW'(CELL_H - 1)) begin
              r_py  <= '0;
              r_row <= (r_row == RW'(ROWS)) ? r_row : r_row + RW'(1);
            end else begin
              r_py <= r_py + PYW'(1);
            end
          end else if (r_px == PXW'(CELL_W - 1)) begin
            r_px  <= '0;
            r_col <= (r_col == CW'(COLS)) ? r_col : r_col + CW'(1);
          end else begin
            r_px <= r_px + PXW'(1);
          end
        end
      end
      if (r_phase == 2'd2)
        r_ok <= r_active && r_col < CW'(COLS) && r_row < RW'(ROWS) && w_code_ok;
      if (r_fetch)
        r_pix <= r_ok ? i_gly_rdata : BG_COLOR;
    end
  end
endmodule

// File: tb/tb_text_glyph_scheduler.sv
// tb_text_glyph_scheduler: directed checks of pixel fetch, cell counters, and write arbitration
module tb_text_glyph_scheduler;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_pix_en = 1'b0;
  logic        i_active = 1'b0;
  logic [9:0]  i_x = '0;
  logic [8:0]  i_y = '0;
  logic [7:0]  o_txt_addr;
  logic        o_txt_wen;
  logic [7:0]  o_txt_wdata;
  logic [7:0]  i_txt_rdata = '0;
  logic [17:0] o_gly_addr;
  logic [11:0] i_gly_rdata = '0;
  logic        i_wr_req = 1'b0;
  logic [7:0]  i_wr_addr = '0;
  logic [7:0]  i_wr_data = '0;
  logic        o_wr_ack;
  logic [11:0] o_pix_color;
  logic [7:0]  txt_mem [256];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  ta;
  logic [17:0] ga;

  text_glyph_scheduler dut (
    .clk(clk), .reset(reset), .i_pix_en(i_pix_en), .i_active(i_active), .i_x(i_x), .i_y(i_y),
    .o_txt_addr(o_txt_addr), .o_txt_wen(o_txt_wen), .o_txt_wdata(o_txt_wdata), .i_txt_rdata(i_txt_rdata),
    .o_gly_addr(o_gly_addr), .i_gly_rdata(i_gly_rdata), .i_wr_req(i_wr_req), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .o_wr_ack(o_wr_ack), .o_pix_color(o_pix_color)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] glyph(input logic [17:0] a);
    return (a == 18'd2500) ? 12'hF0F : (a[11:0] ^ 12'h5A5);
  endfunction

  always @(posedge clk) begin
    i_txt_rdata <= txt_mem[o_txt_addr];
    if (o_txt_wen) txt_mem[o_txt_addr] <= o_txt_wdata;
    i_gly_rdata <= glyph(o_gly_addr);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called on a negedge; returns on the phase-3 negedge with phase-1/phase-2 addresses.
  task automatic do_pix(input logic act, input logic [9:0] x, input logic [8:0] y,
                        output logic [7:0] t_a, output logic [17:0] g_a);
    i_pix_en = 1'b1; i_active = act; i_x = x; i_y = y;
    @(negedge clk); i_pix_en = 1'b0;
    @(negedge clk); t_a = o_txt_addr;
    @(negedge clk); g_a = o_gly_addr;
    @(negedge clk);
  endtask

  logic [7:0]  t4_code [6] = '{8'd34, 8'd32, 8'd34, 8'd200, 8'd34, 8'd34};
  logic        t4_act  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [11:0] t4_exp  [6] = '{12'hF0F, 12'h000, 12'hF0F, 12'h000, 12'hF0F, 12'h000};

  initial begin
    for (int i = 0; i < 256; i++) txt_mem[i] = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_pix", 32'(o_pix_color), 32'h000);
    chk("rst_wen", 32'(o_txt_wen), 32'd0);
    chk("rst_ack", 32'(o_wr_ack), 32'd0);
    chk("rst_gly", 32'(o_gly_addr), 32'd0);
    chk("rst_txt", 32'(o_txt_addr), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    txt_mem[0] = 8'd34;
    do_pix(1'b1, 10'd0, 9'd0, ta, ga);
    chk("t2_txt_addr", 32'(ta), 32'd0);
    chk("t2_gly_addr", 32'(ga), 32'd2500);
    @(negedge clk);
    chk("t2_pix", 32'(o_pix_color), 32'hF0F);

    i_pix_en = 1'b1; i_active = 1'b1; i_x = '0; i_y = '0;
    @(negedge clk); i_pix_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; i_wr_req = 1'b1; i_wr_addr = 8'd200; i_wr_data = 8'h77;
    @(negedge clk);
    chk("t1_ack_in_rst", 32'(o_wr_ack), 32'd0);
    chk("t1_wen_in_rst", 32'(o_txt_wen), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("t1_pix_in_rst", 32'(o_pix_color), 32'h000);
    reset = 1'b0;
    #1;
    chk("t1_ack_after", 32'(o_wr_ack), 32'd1);
    chk("t1_addr_after", 32'(o_txt_addr), 32'd200);
    @(negedge clk); i_wr_req = 1'b0;
    chk("t1_oob_written", 32'(txt_mem[200]), 32'h77);
    repeat (4) @(negedge clk);
    chk("t1_pix_bg", 32'(o_pix_color), 32'h000);
    do_pix(1'b1, 10'd0, 9'd0, ta, ga);
    @(negedge clk);
    chk("t1_resume_pix", 32'(o_pix_color), 32'hF0F);

    for (int i = 0; i < 6; i++) begin
      txt_mem[0] = t4_code[i];
      do_pix(t4_act[i], 10'd0, 9'd0, ta, ga);
      @(negedge clk);
      chk($sformatf("t4_pix_%0d", i), 32'(o_pix_color), 32'(t4_exp[i]));
    end

    txt_mem[0] = 8'd34;
    i_pix_en = 1'b1; i_active = 1'b1; i_x = '0; i_y = '0;
    @(negedge clk); i_pix_en = 1'b0;
    @(negedge clk);
    i_wr_req = 1'b1; i_wr_addr = 8'd5; i_wr_data = 8'd66;
    #1;
    chk("t5_ack_ph1", 32'(o_wr_ack), 32'd0);
    chk("t5_wen_ph1", 32'(o_txt_wen), 32'd0);
    chk("t5_addr_ph1", 32'(o_txt_addr), 32'd0);
    @(negedge clk);
    chk("t5_ack_ph2", 32'(o_wr_ack), 32'd0);
    chk("t5_gly_ph2", 32'(o_gly_addr), 32'd2500);
    @(negedge clk);
    chk("t5_ack_ph3", 32'(o_wr_ack), 32'd1);
    chk("t5_wen_ph3", 32'(o_txt_wen), 32'd1);
    chk("t5_addr_ph3", 32'(o_txt_addr), 32'd5);
    chk("t5_wdata_ph3", 32'(o_txt_wdata), 32'd66);
    @(negedge clk); i_wr_req = 1'b0;
    chk("t5_pix", 32'(o_pix_color), 32'hF0F);
    chk("t5_mem", 32'(txt_mem[5]), 32'd66);

    txt_mem[12] = 8'd40; txt_mem[13] = 8'd65; txt_mem[24] = 8'd34;
    for (int y = 0; y <= 50; y++) do_pix(1'b1, 10'd0, 9'(y), ta, ga);
    for (int x = 0; x <= 600; x++) begin
      do_pix(1'b1, 10'(x), 9'd51, ta, ga);
      case (x)
        0:   begin chk("t3_x0_txt", 32'(ta), 32'd12); chk("t3_x0_gly", 32'(ga), 32'd17550); end
        49:  begin chk("t3_x49_txt", 32'(ta), 32'd12); chk("t3_x49_gly", 32'(ga), 32'd17599); end
        50:  begin chk("t3_x50_txt", 32'(ta), 32'd13); chk("t3_x50_gly", 32'(ga), 32'd80050); end
        99:  begin chk("t3_x99_txt", 32'(ta), 32'd13); chk("t3_x99_gly", 32'(ga), 32'd80099); end
        600: chk("t3_colsat_txt", 32'(ta), 32'd24);
        default: ;
      endcase
    end
    @(negedge clk);
    chk("t3_colsat_pix", 32'(o_pix_color), 32'h000);

    i_wr_req = 1'b1; i_wr_addr = 8'd0; i_wr_data = 8'd65;
    #1;
    chk("t6_ack_idle", 32'(o_wr_ack), 32'd1);
    @(negedge clk); i_wr_req = 1'b0;
    do_pix(1'b1, 10'd0, 9'd0, ta, ga);
    chk("t6_txt_addr", 32'(ta), 32'd0);
    chk("t6_gly_addr", 32'(ga), 32'd80000);
    @(negedge clk);
    chk("t6_pix", 32'(o_pix_color), 32'(12'(18'd80000) ^ 12'h5A5));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
